// File: rtl/ahb_trace_defs.sv
// ahb_trace_defs: shared AHB constants and trace entry layout {addr, size, write, data, resp}.
package ahb_trace_defs;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int ENTRY_W = DEF_AW + 3 + 1 + DEF_DW + 1;
  localparam int OFF_RESP = 0;
  localparam int OFF_DATA = 1;
  function automatic int entry_w(int aw, int dw);
    return aw + 3 + 1 + dw + 1;
  endfunction
  function automatic int off_write(int dw);
    return dw + 1;
  endfunction
  function automatic int off_size(int dw);
    return dw + 2;
  endfunction
  function automatic int off_addr(int dw);
    return dw + 5;
  endfunction
endpackage

// File: rtl/ahb_trace_fifo.sv
// ahb_trace_fifo: DEPTH-entry trace storage with optional overwrite-oldest when full.
module ahb_trace_fifo #(
  parameter int W = 69,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          clr,
  input  logic          wrap,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [PW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overwrote
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic do_pop, wr;
  assign empty = level == '0;
  assign full = level == (PW+1)'(DEPTH);
  assign do_pop = pop & !empty;
  assign overwrote = push & full & !do_pop & wrap;
  assign wr = push & (!full | do_pop | wrap);
  assign dout = empty ? '0 : mem[head];
  always_ff @(posedge clk)
    if (wr) mem[tail] <= din;
  // an overwrite retires the oldest entry, so head moves while level holds at DEPTH
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      head <= '0;
      tail <= '0;
      level <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      level <= '0;
    end else begin
      if (wr) tail <= tail + 1'b1;
      if (do_pop | overwrote) head <= head + 1'b1;
      level <= level + (PW+1)'(wr) - (PW+1)'(do_pop | overwrote);
    end
endmodule

// File: rtl/ahb_trace_buffer.sv
// ahb_trace_buffer: passive AHB-Lite monitor capturing filtered completed transfers into a trace FIFO.
module ahb_trace_buffer
  import ahb_trace_defs::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 16,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [AW-1:0]            ahb_haddr,
  input  logic [2:0]               ahb_hsize,
  input  logic [1:0]               ahb_htrans,
  input  logic                     ahb_hwrite,
  input  logic [DW-1:0]            ahb_hwdata,
  input  logic [DW-1:0]            ahb_hrdata,
  input  logic                     ahb_hready,
  input  logic                     ahb_hresp,
  input  logic                     cfg_enable,
  input  logic                     cfg_wrap,
  input  logic [AW-1:0]            cfg_addr_lo,
  input  logic [AW-1:0]            cfg_addr_hi,
  input  logic                     cfg_clear,
  input  logic                     rd_pop,
  output logic                     rd_valid,
  output logic [AW-1:0]            rd_addr,
  output logic [2:0]               rd_size,
  output logic                     rd_write,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_resp,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNTW-1:0]          cnt_init,
  output logic [CNTW-1:0]          cnt_done,
  output logic [CNTW-1:0]          cnt_drop
);
  localparam int EW = entry_w(AW, DW);
  logic [EW-1:0] din, dout;
  logic pend, p_write, accept, done, push, drop, full, empty, overwrote;
  logic [AW-1:0] p_addr;
  logic [2:0] p_size;
  assign accept = ahb_hready & (ahb_htrans == HTRANS_NONSEQ || ahb_htrans == HTRANS_SEQ) & cfg_enable
                & ahb_haddr >= cfg_addr_lo & ahb_haddr <= cfg_addr_hi;
  assign done = pend & ahb_hready;
  assign push = done & !cfg_clear;
  assign drop = push & full & !rd_pop & !cfg_wrap;
  assign din = {p_addr, p_size, p_write, p_write ? ahb_hwdata : ahb_hrdata, ahb_hresp};
  assign rd_valid = !empty;
  assign rd_addr = dout[off_addr(DW) +: AW];
  assign rd_size = dout[off_size(DW) +: 3];
  assign rd_write = dout[off_write(DW)];
  assign rd_data = dout[OFF_DATA +: DW];
  assign rd_resp = dout[OFF_RESP];
  ahb_trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .aresetn(aresetn), .clr(cfg_clear), .wrap(cfg_wrap), .push(push), .pop(rd_pop),
    .din(din), .dout(dout), .level(level), .full(full), .empty(empty), .overwrote(overwrote)
  );
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      pend <= 1'b0;
      p_addr <= '0;
      p_size <= '0;
      p_write <= 1'b0;
      cnt_init <= '0;
      cnt_done <= '0;
      cnt_drop <= '0;
      overflow <= 1'b0;
    end else if (cfg_clear) begin
      pend <= 1'b0;
      cnt_init <= '0;
      cnt_done <= '0;
      cnt_drop <= '0;
      overflow <= 1'b0;
    end else begin
      // a new address phase on the completion edge keeps the pipeline occupied
      if (accept) begin
        pend <= 1'b1;
        p_addr <= ahb_haddr;
        p_size <= ahb_hsize;
        p_write <= ahb_hwrite;
      end else if (done) pend <= 1'b0;
      cnt_init <= cnt_init + CNTW'(accept);
      cnt_done <= cnt_done + CNTW'(push & !drop);
      if (drop && cnt_drop != '1) cnt_drop <= cnt_drop + 1'b1;
      overflow <= overflow | overwrote;
    end
endmodule

// File: tb/tb_ahb_trace_buffer.sv
// tb_ahb_trace_buffer: directed AHB traffic checked against a queue-based trace model every cycle.
module tb_ahb_trace_buffer;
  localparam int DEPTH = 16;
  logic clk = 0, aresetn = 0;
  logic [31:0] haddr = 0, hwdata = 0, hrdata = 0, lo = 0, hi = '1;
  logic [2:0] hsize = 0;
  logic [1:0] htrans = 0;
  logic hwrite = 0, hready = 1, hresp = 0, cfg_enable = 0, cfg_wrap = 0, cfg_clear = 0, rd_pop = 0;
  logic rd_valid, rd_write, rd_resp, overflow;
  logic [31:0] rd_addr, rd_data;
  logic [2:0] rd_size;
  logic [4:0] level;
  logic [15:0] cnt_init, cnt_done, cnt_drop;
  int n_cmp = 0, n_err = 0;

  ahb_trace_buffer dut (
    .clk(clk), .aresetn(aresetn), .ahb_haddr(haddr), .ahb_hsize(hsize), .ahb_htrans(htrans),
    .ahb_hwrite(hwrite), .ahb_hwdata(hwdata), .ahb_hrdata(hrdata), .ahb_hready(hready), .ahb_hresp(hresp),
    .cfg_enable(cfg_enable), .cfg_wrap(cfg_wrap), .cfg_addr_lo(lo), .cfg_addr_hi(hi), .cfg_clear(cfg_clear),
    .rd_pop(rd_pop), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_size(rd_size), .rd_write(rd_write),
    .rd_data(rd_data), .rd_resp(rd_resp), .level(level), .overflow(overflow),
    .cnt_init(cnt_init), .cnt_done(cnt_done), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {logic [31:0] a; logic [2:0] s; logic w; logic [31:0] d; logic r;} ent_t;
  ent_t q[$];
  logic m_pend, m_w, m_ovf;
  logic [31:0] m_a;
  logic [2:0] m_s;
  logic [15:0] m_init, m_done, m_drop;

  // reference: a trace is a queue of completed transfers; the pending transfer is one remembered address phase
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn || cfg_clear) begin
      q.delete();
      m_pend = 0; m_ovf = 0; m_init = 0; m_done = 0; m_drop = 0;
    end else begin
      ent_t e;
      bit acc, completes;
      acc = hready && htrans[1] && cfg_enable && haddr >= lo && haddr <= hi;
      completes = m_pend && hready;
      e = '{m_a, m_s, m_w, m_w ? hwdata : hrdata, hresp};
      if (rd_pop && q.size() > 0) void'(q.pop_front());
      if (completes) begin
        if (q.size() < DEPTH) begin q.push_back(e); m_done++; end
        else if (cfg_wrap) begin void'(q.pop_front()); q.push_back(e); m_ovf = 1; m_done++; end
        else if (m_drop != 16'hFFFF) m_drop++;
      end
      if (acc) begin m_pend = 1; m_a = haddr; m_s = hsize; m_w = hwrite; m_init++; end
      else if (completes) m_pend = 0;
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", 64'(rd_valid), 64'(q.size() > 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("cnt_init", 64'(cnt_init), 64'(m_init));
    chk("cnt_done", 64'(cnt_done), 64'(m_done));
    chk("cnt_drop", 64'(cnt_drop), 64'(m_drop));
    if (q.size() > 0) begin
      chk("rd_addr", 64'(rd_addr), 64'(q[0].a));
      chk("rd_size", 64'(rd_size), 64'(q[0].s));
      chk("rd_write", 64'(rd_write), 64'(q[0].w));
      chk("rd_data", 64'(rd_data), 64'(q[0].d));
      chk("rd_resp", 64'(rd_resp), 64'(q[0].r));
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); htrans = 2'b00; hready = 1; hresp = 0; rd_pop = 0; cfg_clear = 0; end
  endtask

  task automatic clear();
    step(); htrans = 2'b00; cfg_clear = 1;
    step(); cfg_clear = 0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int waits,
                      input logic err, input logic pp, input logic [1:0] tr);
    step(); haddr = a; htrans = tr; hwrite = w; hsize = w ? 3'd2 : 3'd1; hready = 1; hresp = 0;
    repeat (waits) begin step(); htrans = 2'b00; hready = 0; hresp = err; hwdata = 32'hDEAD; hrdata = 32'hBEEF; end
    step(); htrans = 2'b00; hready = 1; hresp = err; rd_pop = pp;
    if (w) hwdata = d; else hrdata = d;
    idle(1);
  endtask

  // pipelined writes: the address of transfer i overlaps the data phase of transfer i-1 (data = i)
  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i <= n; i++) begin
      step();
      if (i < n) begin haddr = base + 32'(4 * i); htrans = 2'b10; hwrite = 1; hsize = 3'd2; end
      else htrans = 2'b00;
      if (i > 0) hwdata = 32'(i);
    end
    idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #3;
    chk("reset_level", 64'(level), 0);
    chk("reset_valid", 64'(rd_valid), 0);
    chk("reset_cnt_init", 64'(cnt_init), 0);
    step(); aresetn = 1; cfg_enable = 1;
    xfer(32'h100, 1, 32'hA5A5A5A5, 0, 0, 0, 2'b10);
    chk("t1_addr", 64'(rd_addr), 64'h100);
    chk("t1_write", 64'(rd_write), 1);
    chk("t1_data", 64'(rd_data), 64'hA5A5A5A5);
    chk("t1_resp", 64'(rd_resp), 0);
    chk("t1_init", 64'(cnt_init), 1);
    chk("t1_done", 64'(cnt_done), 1);
    chk("t1_model_addr", 64'(q[0].a), 64'h100);
    step(); rd_pop = 1;
    idle(1);
    xfer(32'h104, 0, 32'h1234, 2, 0, 0, 2'b10);
    chk("t2_data", 64'(rd_data), 64'h1234);
    chk("t2_write", 64'(rd_write), 0);
    chk("t2_done", 64'(cnt_done), 2);
    clear();
    lo = 32'h200; hi = 32'h2FF;
    xfer(32'h1FC, 1, 1, 0, 0, 0, 2'b10);
    xfer(32'h200, 1, 2, 0, 0, 0, 2'b10);
    xfer(32'h2FF, 0, 3, 0, 0, 0, 2'b11);
    xfer(32'h300, 1, 4, 0, 0, 0, 2'b10);
    xfer(32'h210, 1, 5, 0, 0, 0, 2'b01);
    chk("t3_init", 64'(cnt_init), 2);
    chk("t3_level", 64'(level), 2);
    chk("t3_head", 64'(rd_addr), 64'h200);
    chk("t3_model_size", 64'(q.size()), 2);
    lo = 0; hi = '1;
    clear();
    fill(DEPTH + 3, 32'h1000);
    chk("t4_level", 64'(level), DEPTH);
    chk("t4_drop", 64'(cnt_drop), 3);
    chk("t4_head", 64'(rd_addr), 64'h1000);
    chk("t4_head_data", 64'(rd_data), 1);
    chk("t4_ovf", 64'(overflow), 0);
    xfer(32'h500, 1, 32'h55, 0, 0, 1, 2'b10);
    chk("t6_level", 64'(level), DEPTH);
    chk("t6_drop", 64'(cnt_drop), 3);
    chk("t6_head", 64'(rd_addr), 64'h1004);
    clear();
    cfg_wrap = 1;
    fill(DEPTH + 3, 32'h1000);
    chk("t5_level", 64'(level), DEPTH);
    chk("t5_ovf", 64'(overflow), 1);
    chk("t5_head", 64'(rd_addr), 64'h100C);
    chk("t5_done", 64'(cnt_done), DEPTH + 3);
    chk("t5_model_head", 64'(q[0].d), 4);
    step(); haddr = 32'h600; htrans = 2'b10; hwrite = 1;
    step(); htrans = 2'b00; hwdata = 32'h77; cfg_clear = 1;
    idle(3);
    chk("t9_level", 64'(level), 0);
    chk("t9_ovf", 64'(overflow), 0);
    chk("t9_init", 64'(cnt_init), 0);
    chk("t9_done", 64'(cnt_done), 0);
    xfer(32'h700, 1, 32'hE0, 1, 1, 0, 2'b10);
    chk("t7_level", 64'(level), 1);
    chk("t7_resp", 64'(rd_resp), 1);
    chk("t7_done", 64'(cnt_done), 1);
    clear();
    xfer(32'h704, 1, 32'hE4, 0, 0, 1, 2'b10);
    chk("t8_level", 64'(level), 1);
    chk("t8_data", 64'(rd_data), 64'hE4);
    clear();
    step(); haddr = 32'h800; htrans = 2'b10; hwrite = 0;
    step(); htrans = 2'b00; hrdata = 32'h88; cfg_enable = 0;
    idle(1);
    xfer(32'h804, 1, 32'h99, 0, 0, 0, 2'b10);
    chk("t10_level", 64'(level), 1);
    chk("t10_data", 64'(rd_data), 64'h88);
    chk("t10_init", 64'(cnt_init), 1);
    cfg_enable = 1;
    fill(3, 32'h900);
    step(); aresetn = 0;
    #1;
    chk("t11_level", 64'(level), 0);
    chk("t11_valid", 64'(rd_valid), 0);
    chk("t11_init", 64'(cnt_init), 0);
    chk("t11_done", 64'(cnt_done), 0);
    step(); aresetn = 1;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
